// File: rtl/alu_issue_queue.sv
// Purpose: issue queue in front of the combinational 32-bit ALU; buffers ops, drives head to ALU, registers result.
// Latency: 2 edges minimum (push edge, then pop edge into the result register); 1 op/cycle sustained.
// Backpressure: in_ready drops when the FIFO is full or during flush; head pops only when the result register is free or draining.
module alu_issue_queue #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [31:0]                  in_a,
   input  logic [31:0]                  in_b,
   input  logic [2:0]                   in_op,
   input  logic [TAG_W-1:0]             in_tag,
   output logic [31:0]                  alu_a,
   output logic [31:0]                  alu_b,
   output logic [2:0]                   alu_ctrl,
   input  logic [31:0]                  alu_result,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [31:0]                  out_result,
   output logic [TAG_W-1:0]             out_tag,
   output logic                         out_illegal,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   typedef struct packed {
      logic [31:0]      a;
      logic [31:0]      b;
      logic [2:0]       op;
      logic [TAG_W-1:0] tag;
   } entry_t;

   // Only ADD, SUB, AND, XOR and SLT are implemented by the ALU.
   function automatic logic op_illegal(input logic [2:0] op);
      case (op)
         3'b000, 3'b001, 3'b010, 3'b011, 3'b101: op_illegal = 1'b0;
         default:                                op_illegal = 1'b1;
      endcase
   endfunction

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             out_valid_q, out_valid_d;
   logic [31:0]      out_result_q, out_result_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;
   logic             out_illegal_q, out_illegal_d;

   entry_t head;
   logic   empty, full, push, pop, head_illegal;

   assign head         = mem_q[rptr_q];
   assign empty        = (count_q == '0);
   assign full         = (count_q == CNT_W'(DEPTH));
   assign head_illegal = op_illegal(head.op);

   // Readiness is purely state-based: a full queue never accepts, even if it pops this cycle.
   assign in_ready = !full && !flush;
   assign push     = in_valid && in_ready;
   assign pop      = !empty && (!out_valid_q || out_ready) && !flush;

   assign out_valid   = out_valid_q;
   assign out_result  = out_result_q;
   assign out_tag     = out_tag_q;
   assign out_illegal = out_illegal_q;
   assign count       = count_q;

   // Head entry feeds the ALU; idle or illegal heads present a harmless ADD of zeros/operands.
   always_comb begin
      alu_a    = '0;
      alu_b    = '0;
      alu_ctrl = '0;
      if (!empty) begin
         alu_a    = head.a;
         alu_b    = head.b;
         alu_ctrl = head_illegal ? 3'b000 : head.op;
      end
   end

   // Next-state for pointers, occupancy and the result register; flush overrides everything.
   always_comb begin
      wptr_d        = wptr_q;
      rptr_d        = rptr_q;
      count_d       = count_q;
      out_valid_d   = out_valid_q;
      out_result_d  = out_result_q;
      out_tag_d     = out_tag_q;
      out_illegal_d = out_illegal_q;
      if (flush) begin
         wptr_d      = '0;
         rptr_d      = '0;
         count_d     = '0;
         out_valid_d = 1'b0;
      end else begin
         if (push) wptr_d = wptr_q + PTR_W'(1);
         if (pop) begin
            rptr_d        = rptr_q + PTR_W'(1);
            out_result_d  = head_illegal ? 32'h0 : alu_result;
            out_tag_d     = head.tag;
            out_illegal_d = head_illegal;
            out_valid_d   = 1'b1;
         end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Payload storage carries no reset; occupancy tracking decides what is meaningful.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= '{a: in_a, b: in_b, op: in_op, tag: in_tag};
   end

   // Control state and result register, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q        <= '0;
         rptr_q        <= '0;
         count_q       <= '0;
         out_valid_q   <= 1'b0;
         out_result_q  <= '0;
         out_tag_q     <= '0;
         out_illegal_q <= 1'b0;
      end else begin
         wptr_q        <= wptr_d;
         rptr_q        <= rptr_d;
         count_q       <= count_d;
         out_valid_q   <= out_valid_d;
         out_result_q  <= out_result_d;
         out_tag_q     <= out_tag_d;
         out_illegal_q <= out_illegal_d;
      end
   end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: directed scenarios plus randomized traffic.
// Expected results come from an operation-level reference model pushed into a scoreboard queue.
// A negedge monitor pops and compares every delivered result.
module tb_alu_issue_queue;
   localparam int DEPTH = 4;
   localparam int TAG_W = 4;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic              clk, rst_n, flush, in_valid, in_ready;
   logic [31:0]       in_a, in_b, alu_a, alu_b, alu_result, out_result;
   logic [2:0]        in_op, alu_ctrl;
   logic [TAG_W-1:0]  in_tag, out_tag;
   logic              out_valid, out_ready, out_illegal;
   logic [CNT_W-1:0]  count;

   typedef struct {
      logic [31:0]      res;
      logic [TAG_W-1:0] tag;
      logic             ill;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_acc   = 0;

   alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag), .out_illegal(out_illegal),
      .count(count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // The external ALU: unsupported control codes yield garbage.
   always_comb begin
      alu_result = 32'hDEAD_BEEF;
      case (alu_ctrl)
         3'b000: alu_result = alu_a + alu_b;
         3'b001: alu_result = alu_a - alu_b;
         3'b010: alu_result = alu_a & alu_b;
         3'b011: alu_result = alu_a ^ alu_b;
         3'b101: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
         default: alu_result = 32'hDEAD_BEEF;
      endcase
   end

   // What the queue should deliver for one operation.
   function automatic exp_t ref_op(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [TAG_W-1:0] tag);
      exp_t e;
      e.tag = tag;
      e.ill = 1'b0;
      case (op)
         3'd0: e.res = a + b;
         3'd1: e.res = a - b;
         3'd2: e.res = a & b;
         3'd3: e.res = a ^ b;
         3'd5: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: begin e.res = 32'd0; e.ill = 1'b1; end
      endcase
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   // One clock of stimulus: entered and left at posedge+1; acceptance recorded at the negedge.
   task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [TAG_W-1:0] tag);
      in_valid = v; in_a = a; in_b = b; in_op = op; in_tag = tag;
      @(negedge clk);
      if (v && in_ready) begin
         exp_q.push_back(ref_op(op, a, b, tag));
         n_acc++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 32'd0, 32'd0, 3'd0, '0);
   endtask

   // Scoreboard monitor: every result handshake must match the oldest outstanding operation.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst_n || flush) begin
         exp_q.delete();
      end else if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: actual result %0h with nothing outstanding", out_result);
         end else begin
            e = exp_q.pop_front();
            chk("sb_result",  out_result,        e.res);
            chk("sb_tag",     32'(out_tag),      32'(e.tag));
            chk("sb_illegal", 32'(out_illegal),  32'(e.ill));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acc0;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
      in_op = '0; in_tag = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(count), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      rst_n = 1'b1;

      // Reset asserted mid-operation clears held state immediately.
      cyc(1'b1, 32'd1, 32'd2, 3'd0, 4'd5);
      cyc(1'b1, 32'd3, 32'd4, 3'd0, 4'd6);
      chk("pre_rst_valid", 32'(out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 0);
      chk("arst_count", 32'(count), 0);
      chk("arst_out_result", out_result, 0);
      chk("arst_out_tag", 32'(out_tag), 0);
      chk("arst_out_illegal", 32'(out_illegal), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("post_rst_in_ready", 32'(in_ready), 1);
      chk("post_rst_count", 32'(count), 0);

      // Single ADD: head visible one edge after push, result after the second edge.
      out_ready = 1'b1;
      cyc(1'b1, 32'd5, 32'd7, 3'd0, 4'd3);
      chk("single_alu_ctrl", 32'(alu_ctrl), 0);
      chk("single_alu_a", alu_a, 5);
      chk("single_alu_b", alu_b, 7);
      chk("single_not_yet_valid", 32'(out_valid), 0);
      idle();
      chk("single_valid", 32'(out_valid), 1);
      chk("single_result", out_result, 12);
      chk("single_tag", 32'(out_tag), 3);
      idle();

      // Back-to-back SUB, SLT, XOR emerge on consecutive cycles.
      cyc(1'b1, 32'd3, 32'd5, 3'd1, 4'd1);
      cyc(1'b1, 32'hFFFF_FFFF, 32'd1, 3'd5, 4'd2);
      chk("seq_sub", out_result, 32'hFFFF_FFFE);
      cyc(1'b1, 32'hF0F0_F0F0, 32'hFFFF_0000, 3'd3, 4'd4);
      chk("seq_slt", out_result, 32'd1);
      idle();
      chk("seq_xor", out_result, 32'h0F0F_F0F0);
      chk("seq_xor_valid", 32'(out_valid), 1);
      idle();
      idle();

      // Backpressure: DEPTH+1 accepted, then drain in order.
      out_ready = 1'b0;
      acc0 = n_acc;
      for (int i = 0; i < 6; i++) cyc(1'b1, 32'(i * 11), 32'(i + 1), 3'd0, 4'(i + 8));
      chk("bp_accepted", 32'(n_acc - acc0), 5);
      chk("bp_count_full", 32'(count), 4);
      chk("bp_in_ready_low", 32'(in_ready), 0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      idle();
      chk("bp_in_ready_back", 32'(in_ready), 1);
      chk("bp_count_after_pop", 32'(count), 3);
      repeat (4) idle();
      chk("bp_drained_valid", 32'(out_valid), 0);
      chk("bp_drained_count", 32'(count), 0);

      // Illegal op: ALU sees ADD, result forced to zero, tag kept.
      cyc(1'b1, 32'd9, 32'd9, 3'b111, 4'hA);
      chk("ill_alu_ctrl", 32'(alu_ctrl), 0);
      chk("ill_alu_a", alu_a, 9);
      idle();
      chk("ill_result", out_result, 0);
      chk("ill_flag", 32'(out_illegal), 1);
      chk("ill_tag", 32'(out_tag), 32'hA);
      idle();

      // Flush with three queued and one held, concurrent push rejected.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) cyc(1'b1, 32'(100 + i), 32'd1, 3'd1, 4'(i));
      chk("fl_count_before", 32'(count), 3);
      chk("fl_valid_before", 32'(out_valid), 1);
      acc0 = n_acc;
      flush = 1'b1;
      cyc(1'b1, 32'd77, 32'd1, 3'd0, 4'hF);
      chk("fl_in_ready_during", 32'(in_ready), 0);
      chk("fl_count_after", 32'(count), 0);
      chk("fl_valid_after", 32'(out_valid), 0);
      chk("fl_push_rejected", 32'(n_acc - acc0), 0);
      flush = 1'b0;
      out_ready = 1'b1;
      cyc(1'b1, 32'd20, 32'd22, 3'd2, 4'h7);
      idle();
      chk("fl_recover_valid", 32'(out_valid), 1);
      chk("fl_recover_result", out_result, 32'd20 & 32'd22);
      idle();

      // Randomized traffic with occasional flushes and illegal codes.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a, b;
         a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 49) == 0);
         cyc(1'($urandom_range(0, 1)), a, b, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
         chk("rnd_occupancy", 32'(count) + 32'(out_valid), 32'(exp_q.size()));
         if (count > CNT_W'(DEPTH)) chk("rnd_count_bound", 32'(count), DEPTH);
      end
      flush = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 40 && (exp_q.size() != 0 || out_valid); i++) idle();
      chk("final_drain", 32'(exp_q.size()), 0);
      chk("final_out_valid", 32'(out_valid), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Issue stage placed directly upstream of the 32-bit ALU.
- Buffers ALU operations arriving on a valid/ready handshake in a DEPTH-entry FIFO.
- Drives the head entry's operands and 3-bit ALU control onto the combinational ALU.
- Captures the ALU result into an output register with its own valid/ready handshake, so decode and writeback can stall independently.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- TAG_W, 4: width of the opaque tag carried with each operation.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous queue/output clear.
- in_valid  input  1  upstream operation valid.
- in_ready  output  1  queue can accept this cycle.
- in_a  input  32  operand A.
- in_b  input  32  operand B.
- in_op  input  3  ALU control code.
- in_tag  input  TAG_W  operation tag.
- alu_a  output  32  to ALU operand A.
- alu_b  output  32  to ALU operand B.
- alu_ctrl  output  3  to ALU control.
- alu_result  input  32  from ALU result.
- out_valid  output  1  result register valid.
- out_ready  input  1  downstream accepts result.
- out_result  output  32  registered result.
- out_tag  output  TAG_W  tag of the result.
- out_illegal  output  1  operation had an unsupported code.
- count  output  $clog2(DEPTH+1)  FIFO occupancy, excluding the output register.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: count=0, read/write pointers=0, out_valid=0, out_result=0, out_tag=0, out_illegal=0. Reset asserted mid-operation discards all queued and held operations immediately.
- Legal codes: 000 ADD, 001 SUB, 010 AND, 011 XOR, 101 SLT. Codes 100, 110, 111 are illegal.
- in_ready = (count < DEPTH) and not flush. It is purely state-based; no same-cycle pass-through when full.
- Push: on a clock edge where in_valid and in_ready are both high, write {a, b, op, tag} at wptr. wptr wraps modulo DEPTH.
- ALU drive (combinational from head entry):
  - Non-empty: alu_a/alu_b/alu_ctrl come from the head entry.
  - Empty: all three are 0.
  - Illegal op at head: alu_ctrl = 000.
- Pop condition: count > 0 and (out_valid == 0 or out_ready == 1). On pop:
  - out_result <= 0 if the head op is illegal, else alu_result.
  - out_tag <= head tag; out_illegal <= head illegal flag; out_valid <= 1.
  - rptr advances modulo DEPTH.
- Output release: out_valid && out_ready with no pop gives out_valid <= 0. Data registers hold their last value.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- No bypass: an entry pushed into an empty queue becomes head after that edge.
- Minimum latency: 2 edges (push edge, then pop edge). out_valid is high after the second edge.
- Sustained throughput: 1 op/cycle while out_ready = 1.
- Capacity: with out_ready held 0, DEPTH+1 ops are accepted (DEPTH in the FIFO, 1 in the output register).
- Flush (synchronous, takes priority over push and pop): pointers and count reset to 0 and out_valid <= 0 on the next edge. in_ready = 0 during the flush cycle.
- Occupancy: count never exceeds DEPTH and never underflows. No push when full; no pop when empty.

Test Plan:
1. Reset: assert rst_n=0 asynchronously mid-cycle -> outputs immediately 0. Then in_ready=1, count=0.
2. Single op: ADD a=5, b=7, tag=3, out_ready=1 -> alu_ctrl=000 one cycle after push. out_valid=1, out_result=12, out_tag=3 after the second edge.
3. Arithmetic sequence SUB, SLT, XOR with out_ready=1:
   - SUB 3,5 -> 0xFFFFFFFE.
   - SLT 0xFFFFFFFF,1 -> 1.
   - XOR 0xF0F0F0F0,0xFFFF0000 -> 0x0F0FF0F0.
   - Results appear on consecutive cycles in order.
4. Backpressure: out_ready=0, push 6 ops (DEPTH=4) -> exactly 5 accepted, count=4, in_ready=0. Then out_ready=1 -> 5 results drain in order, one per cycle, and in_ready returns high the cycle after the first pop.
5. Illegal op: in_op=111, a=9, b=9 -> alu_ctrl=000, out_result=0, out_illegal=1, tag preserved.
6. Flush: with 3 ops queued and out_valid=1, pulse flush for one cycle together with in_valid=1 -> next cycle count=0, out_valid=0, and the concurrent push is not accepted.
